// File: rtl/extio_mailbox_pkg.sv
// ----------------------------------------------------------------------------
// extio_pkg : register offsets, STATUS/CTRL bit positions, bus-cycle states
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package extio_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  localparam int ST_RX_NEMPTY = 0;
  localparam int ST_TX_NFULL  = 1;
  localparam int ST_RX_FULL   = 2;
  localparam int ST_TX_EMPTY  = 3;
  localparam int ST_OVER      = 4;
  localparam int ST_UNDER     = 5;

  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;
  localparam int CTRL_FLUSH = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACTIVE = 2'd2
  } cyc_state_t;

endpackage

`default_nettype wire

// File: rtl/extio_mailbox_if.sv
// ----------------------------------------------------------------------------
// extio_mailbox_if : 6809 external I/O bus as seen by the mailbox target
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface extio_mailbox_if;
  logic       E;
  logic       nCSEXTIO;
  logic       RnW;
  logic [1:0] ADDR;
  logic [7:0] DATA_in;
  logic [7:0] DATA_out;
  logic       DATA_oe;
  logic       MRDY;

  modport master (
    output E, nCSEXTIO, RnW, ADDR, DATA_in,
    input  DATA_out, DATA_oe, MRDY
  );

  modport slave (
    input  E, nCSEXTIO, RnW, ADDR, DATA_in,
    output DATA_out, DATA_oe, MRDY
  );
endinterface

`default_nettype wire

// File: rtl/extio_mailbox_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo : single-clock FIFO with wrap-bit pointers and a priority flush
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) & (wr_ptr[AW] != rd_ptr[AW]);
  // Flush beats any push or pop landing on the same edge
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/extio_mailbox.sv
// ----------------------------------------------------------------------------
// extio_mailbox : 6809 EXTIO bus target bridging the CPU to an RX/TX byte agent
//                 Optional nIRQ output when EXTIO_MAILBOX_IRQ_EN is defined.
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module extio_mailbox
  import extio_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [7:0]  RESET_CTRL  = 8'h00
) (
  input  logic            CLKX4,
  input  logic            RESET,
  extio_mailbox_if.slave  bus,
  input  logic [7:0]      RX_DATA,
  input  logic            RX_VALID,
  output logic            RX_READY,
  output logic [7:0]      TX_DATA,
  output logic            TX_VALID,
  input  logic            TX_READY
`ifdef EXTIO_MAILBOX_IRQ_EN
  ,
  output logic            nIRQ
`endif
);

  localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

  cyc_state_t state;
  logic [7:0] wcnt;
  logic       sel, sel_q, mrdy_q;
  logic [1:0] acc_addr;
  logic       acc_rnw;
  logic [7:0] acc_wdata;
  logic       commit, cpu_wr, cpu_rd;
  logic       over_q, under_q;
  logic [7:0] scratch_q;
  logic [1:0] ctrl_lo;
  logic [7:0] rdata;
  logic       rx_push, rx_pop, tx_push, tx_pop, flush;
  logic       rx_full, rx_empty, tx_full, tx_empty;
  logic [7:0] rx_dout, tx_dout;

  assign sel    = ~bus.nCSEXTIO & bus.E;
  assign commit = (state == ACTIVE) & ~sel & sel_q;
  assign cpu_wr = commit & ~acc_rnw;
  assign cpu_rd = commit & acc_rnw;

  always_ff @(posedge CLKX4 or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      wcnt   <= '0;
      mrdy_q <= 1'b1;
      sel_q  <= 1'b0;
    end else begin
      sel_q <= sel;
      case (state)
        IDLE: begin
          if (sel & ~sel_q) begin
            if (WAIT_CYCLES == 0) begin
              state <= ACTIVE;
            end else begin
              state  <= WAIT;
              wcnt   <= WAIT_INIT;
              mrdy_q <= 1'b0;
            end
          end
        end
        WAIT: begin
          // A vanished select abandons the access without any side effect
          if (~sel) begin
            state  <= IDLE;
            mrdy_q <= 1'b1;
          end else if (wcnt == 8'd1) begin
            state  <= ACTIVE;
            mrdy_q <= 1'b1;
          end else begin
            wcnt <= wcnt - 8'd1;
          end
        end
        ACTIVE: begin
          if (~sel & sel_q) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          mrdy_q <= 1'b1;
        end
      endcase
    end
  end

  // Address, direction and write data are held from the last selected cycle
  // so the commit on the E-falling edge does not depend on bus hold time.
  always_ff @(posedge CLKX4 or posedge RESET) begin
    if (RESET) begin
      acc_addr  <= '0;
      acc_rnw   <= 1'b1;
      acc_wdata <= '0;
    end else if (sel) begin
      acc_addr  <= bus.ADDR;
      acc_rnw   <= bus.RnW;
      acc_wdata <= bus.DATA_in;
    end
  end

  always_ff @(posedge CLKX4 or posedge RESET) begin
    if (RESET) begin
      over_q    <= 1'b0;
      under_q   <= 1'b0;
      scratch_q <= 8'h00;
    end else if (cpu_rd) begin
      if ((acc_addr == REG_DATA) && rx_empty) under_q <= 1'b1;
    end else if (cpu_wr) begin
      case (acc_addr)
        REG_DATA: if (tx_full) over_q <= 1'b1;
        REG_STATUS: begin
          if (acc_wdata[ST_OVER])  over_q  <= 1'b0;
          if (acc_wdata[ST_UNDER]) under_q <= 1'b0;
        end
        REG_SCRATCH: scratch_q <= acc_wdata;
        default: ;
      endcase
    end
  end

`ifdef EXTIO_MAILBOX_IRQ_EN
  logic [1:0] ctrl_ie;

  always_ff @(posedge CLKX4 or posedge RESET) begin
    if (RESET) begin
      ctrl_ie <= RESET_CTRL[1:0];
      nIRQ    <= 1'b1;
    end else begin
      if (cpu_wr && (acc_addr == REG_CTRL)) ctrl_ie <= acc_wdata[1:0];
      nIRQ <= ~((ctrl_ie[CTRL_RX_IE] & ~rx_empty) | (ctrl_ie[CTRL_TX_IE] & tx_empty));
    end
  end

  assign ctrl_lo = ctrl_ie;
`else
  logic unused_reset_ctrl;

  assign unused_reset_ctrl = ^RESET_CTRL;
  assign ctrl_lo           = 2'b00;
`endif

  assign rx_push  = RX_VALID & RX_READY;
  assign rx_pop   = cpu_rd & (acc_addr == REG_DATA) & ~rx_empty;
  assign tx_push  = cpu_wr & (acc_addr == REG_DATA);
  assign tx_pop   = TX_VALID & TX_READY;
  assign flush    = cpu_wr & (acc_addr == REG_CTRL) & acc_wdata[CTRL_FLUSH];

  assign RX_READY = ~rx_full & ~RESET;
  assign TX_VALID = ~tx_empty;
  assign TX_DATA  = tx_dout;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (CLKX4),
    .rst   (RESET),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (flush),
    .din   (RX_DATA),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (CLKX4),
    .rst   (RESET),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (flush),
    .din   (acc_wdata),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  always_comb begin
    rdata = 8'h00;
    case (bus.ADDR)
      REG_DATA:    rdata = rx_empty ? 8'h00 : rx_dout;
      REG_STATUS:  rdata = {2'b00, under_q, over_q, tx_empty, rx_full, ~tx_full, ~rx_empty};
      REG_CTRL:    rdata = {6'b000000, ctrl_lo};
      REG_SCRATCH: rdata = scratch_q;
      default:     rdata = 8'h00;
    endcase
  end

  // Read data is forced to zero whenever the buffer is not being driven
  assign bus.DATA_oe  = sel & bus.RnW & (state != IDLE);
  assign bus.DATA_out = bus.DATA_oe ? rdata : 8'h00;
  assign bus.MRDY     = mrdy_q;

endmodule

`default_nettype wire
